// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, width helper and FSM state type for the sorted-sequence counter path.
package pc_pkg;
    localparam int PC_WIDTH = 7;
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/pc_therm_decode.sv
// pc_therm_decode: saturating ones-count to thermometer encoder; counts above WIDTH give all ones.
module pc_therm_decode import pc_pkg::*; #(
    parameter int WIDTH = PC_WIDTH,
    localparam int CW = cw_of(WIDTH)
) (
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] therm,
    output logic             sat
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign therm[i] = count > CW'(i);
    end
    assign sat = count > CW'(WIDTH);
endmodule

// File: rtl/pc_therm_serializer.sv
// pc_therm_serializer: accepts a ones-count and streams its thermometer word out bit-serially, LSB first.
module pc_therm_serializer import pc_pkg::*; #(
    parameter int WIDTH = PC_WIDTH,
    localparam int CW = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic [WIDTH-1:0] therm_word,
    output logic             sat_err
);
    state_t state, state_nxt;
    logic [CW-1:0] beat_idx;
    logic [WIDTH-1:0] therm;
    logic sat, accept, beat_done;

    pc_therm_decode #(.WIDTH(WIDTH)) u_decode (.count(in_count), .therm(therm), .sat(sat));

    assign accept = in_valid & in_ready;
    assign beat_done = ser_valid & ser_ready;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = accept ? SHIFT : (beat_done && ser_last) ? IDLE : state;

    // The last beat's completion doubles as the load slot for back-to-back frames.
    always_comb begin
        ser_valid = state == SHIFT;
        ser_last = ser_valid && beat_idx == CW'(WIDTH - 1);
        ser_bit = ser_valid && therm_word[beat_idx];
        in_ready = !rst && (state == IDLE || (ser_ready && ser_last));
    end

    always_ff @(posedge clk)
        if (rst) begin
            beat_idx <= '0;
            therm_word <= '0;
            sat_err <= 1'b0;
        end else begin
            sat_err <= accept & sat;
            if (accept) begin
                therm_word <= therm;
                beat_idx <= '0;
            end else if (beat_done) beat_idx <= ser_last ? '0 : beat_idx + 1'b1;
        end
endmodule
